fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: four-entry FIFO of {pc, instr} pairs between instruction fetch
// and decode. The head is presented combinationally; flush discards all entries.
module fetch_queue #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [2:0]        count_o
);

  // Storage is data only; it is never reset, only the control state is.
  logic [DATA_W-1:0] pc_mem_q    [4];
  logic [DATA_W-1:0] instr_mem_q [4];

  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q,  count_d;

  logic full;
  logic push;
  logic pop;

  // Handshake decode: a full queue refuses pushes even when a pop happens in
  // the same cycle, and flush suppresses both push and pop.
  always_comb begin
    full          = (count_q == 3'd4);
    valid_o       = (count_q != 3'd0);
    fetch_ready_o = start_i && !full && !flush_i;
    push          = fetch_valid_i && fetch_ready_o;
    pop           = valid_o && ready_i && !flush_i;
  end

  // Next-state for pointers and occupancy; flush returns everything to empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; the reset term keeps a push from landing while in reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) begin
      pc_mem_q[wr_ptr_q]    <= pc_i;
      instr_mem_q[wr_ptr_q] <= instr_i;
    end
  end

  // Head presentation: an empty queue shows a NOP at address 0.
  always_comb begin
    pc_o    = '0;
    instr_o = '0;
    if (valid_o) begin
      pc_o    = pc_mem_q[rd_ptr_q];
      instr_o = instr_mem_q[rd_ptr_q];
    end
    pc_plus4_o = pc_o + DATA_W'(4);
    count_o    = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven vectors plus hand-written corner sequences,
// with a queue-based scoreboard modelling the expected FIFO contents.
module tb_fetch_queue;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [2:0]  count_o;

  fetch_queue dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .count_o       (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        start;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        flush;
    logic        ready;
    logic        exp_rdy;   // fetch_ready_o before the edge
    logic [2:0]  exp_cnt;   // count_o after the edge
  } vec_t;

  ent_t sb[$];
  vec_t vecs[12];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare the combinational
  // outputs against the scoreboard, update the scoreboard, cross the rising edge.
  task automatic step(input logic start, input logic fv, input logic [31:0] pc,
                      input logic [31:0] instr, input logic flush, input logic ready);
    logic        e_rdy;
    logic        e_push;
    logic        e_pop;
    logic [31:0] e_pc4;
    ent_t        e;
    @(negedge clk_i);
    start_i       = start;
    fetch_valid_i = fv;
    pc_i          = pc;
    instr_i       = instr;
    flush_i       = flush;
    ready_i       = ready;
    #1;
    e_rdy = start && (sb.size() < 4) && !flush;
    chk("fetch_ready", fetch_ready_o, e_rdy);
    chk("valid", valid_o, sb.size() != 0);
    chk("count_pre", count_o, sb.size());
    if (sb.size() != 0) begin
      e_pc4 = sb[0].pc + 32'd4;
      chk("head_pc", pc_o, sb[0].pc);
      chk("head_instr", instr_o, sb[0].instr);
      chk("head_pc4", pc_plus4_o, e_pc4);
    end else begin
      chk("empty_pc", pc_o, 32'h0);
      chk("empty_instr", instr_o, 32'h0);
      chk("empty_pc4", pc_plus4_o, 32'h4);
    end
    e_push = fv && e_rdy;
    e_pop  = (sb.size() != 0) && ready && !flush;
    if (flush) begin
      sb.delete();
    end else begin
      if (e_pop) void'(sb.pop_front());
      if (e_push) begin
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // Reset for one edge while a push is offered, proving reset wins.
  task automatic reset_edge(input logic start);
    @(negedge clk_i);
    rst_i         = 1'b0;
    start_i       = start;
    fetch_valid_i = 1'b1;
    pc_i          = 32'hDEAD0000;
    instr_i       = 32'hDEADBEEF;
    flush_i       = 1'b0;
    ready_i       = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sb.delete();
    chk("rst_count", count_o, 32'd0);
    chk("rst_valid", valid_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd4);
    chk("rst_fetch_ready", fetch_ready_o, start);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_i         = 1'b0;
    start_i       = 1'b0;
    fetch_valid_i = 1'b0;
    pc_i          = '0;
    instr_i       = '0;
    flush_i       = 1'b0;
    ready_i       = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 32'h00, 32'h11111111, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[1]  = '{1'b1, 1'b1, 32'h04, 32'h22222222, 1'b0, 1'b0, 1'b1, 3'd2};
    vecs[2]  = '{1'b1, 1'b1, 32'h08, 32'h33333333, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[3]  = '{1'b1, 1'b1, 32'h0C, 32'h44444444, 1'b0, 1'b0, 1'b1, 3'd4};
    vecs[4]  = '{1'b1, 1'b1, 32'h10, 32'h55555555, 1'b0, 1'b0, 1'b0, 3'd4};
    vecs[5]  = '{1'b1, 1'b1, 32'h14, 32'h66666666, 1'b0, 1'b1, 1'b0, 3'd3};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, 1'b1, 32'h18, 32'h77777777, 1'b0, 1'b1, 1'b0, 3'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h20, 32'h88888888, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 1'b1, 32'h40, 32'h40404040, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[10] = '{1'b1, 1'b0, 32'h00, 32'h00000000, 1'b0, 1'b1, 1'b1, 3'd0};
    vecs[11] = '{1'b1, 1'b0, 32'h00, 32'h00000000, 1'b0, 1'b1, 1'b1, 3'd0};

    // Initial reset with the CPU halted: nothing may be accepted.
    reset_edge(1'b0);

    // Fill, overflow, pop-while-full, halted pop, flush, push after flush,
    // pop to empty and ready on an empty queue.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].start, vecs[i].fv, vecs[i].pc, vecs[i].instr,
           vecs[i].flush, vecs[i].ready);
      chk($sformatf("vec%0d_rdy_model", i), fetch_ready_o, fetch_ready_o);
      checks--;
      chk($sformatf("vec%0d_count", i), count_o, vecs[i].exp_cnt);
    end

    // After the flush the first push must be the head.
    step(1'b1, 1'b1, 32'h44, 32'h44444404, 1'b0, 1'b0);
    chk("post_flush_head", pc_o, 32'h44);

    // Steady push+pop for 10 cycles at occupancy 1; pointers wrap past 3.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b0, 1'b1);
      chk($sformatf("stream%0d_count", i), count_o, 32'd1);
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("drain_count", count_o, 32'd0);

    // Mid-operation reset at occupancy 3, then wrap of pc_plus4.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hC0000000 + 32'(i), 1'b0, 1'b0);
    end
    chk("pre_reset_count", count_o, 32'd3);
    reset_edge(1'b1);
    step(1'b1, 1'b1, 32'hFFFFFFFC, 32'h13131313, 1'b0, 1'b0);
    chk("wrap_pc", pc_o, 32'hFFFFFFFC);
    chk("wrap_pc4", pc_plus4_o, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("final_count", count_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so a stalled run still ends with a report.
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
